// File: rtl/hdmi_line_dma.sv
// hdmi_line_dma: scanline fetch engine for the HDMI video path.
// Turns frame/line start strobes into burst reads on the memory interface,
// writes the returned words into one bank of a two-bank line buffer and
// tells the pixel side which bank to display.
//
// Ports:
//   clk, rst                      system clock, synchronous active-high reset
//   cfg_run                       enable; 0 stops new fetches
//   cfg_base, cfg_stride          frame base address, distance between lines
//   cfg_bn_cnt                    number of normal bursts per line
//   cfg_bn_len, cfg_bl_len        normal / last burst length minus 1
//   cfg_vrep                      each source line is shown cfg_vrep+1 times
//   frame_stb, line_stb           frame / line start pulses (clk domain)
//   mi_addr/len/rw/valid/ready    burst request channel (read only)
//   mi_rdata/rstb/rlast           read data return channel
//   buf_waddr/wdata/wren          line buffer write port (MSB of addr = bank)
//   rd_bank                       bank the pixel side must read
//   busy                          fetch in progress
//   underrun                      one-cycle pulse when a fetch is dropped
module hdmi_line_dma #(
  parameter int AW  = 23,
  parameter int LW  = 7,
  parameter int CW  = 7,
  parameter int BAW = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_run,
  input  logic [AW-1:0]  cfg_base,
  input  logic [AW-1:0]  cfg_stride,
  input  logic [CW-1:0]  cfg_bn_cnt,
  input  logic [LW-1:0]  cfg_bn_len,
  input  logic [LW-1:0]  cfg_bl_len,
  input  logic [3:0]     cfg_vrep,
  input  logic           frame_stb,
  input  logic           line_stb,
  output logic [AW-1:0]  mi_addr,
  output logic [LW-1:0]  mi_len,
  output logic           mi_rw,
  output logic           mi_valid,
  input  logic           mi_ready,
  input  logic [15:0]    mi_rdata,
  input  logic           mi_rstb,
  input  logic           mi_rlast,
  output logic [BAW-1:0] buf_waddr,
  output logic [15:0]    buf_wdata,
  output logic           buf_wren,
  output logic           rd_bank,
  output logic           busy,
  output logic           underrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [CW:0]   OUT_ONE   = {{CW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] BURST_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [BAW-2:0] IDX_ONE  = {{(BAW-2){1'b0}}, 1'b1};

  logic [1:0]     state;
  logic [3:0]     rep_cnt;
  logic           wr_bank;
  logic           fetch_bank;
  logic [AW-1:0]  line_addr;
  logic [AW-1:0]  burst_addr;
  logic [CW-1:0]  bursts_left;
  logic [CW:0]    outstanding;
  logic [CW:0]    outstanding_next;
  logic [BAW-2:0] idx;

  logic           frame_go;
  logic           line_go;
  logic           fetch_req;
  logic           accept;
  logic           handshake;
  logic           rdone;
  logic [AW-1:0]  start_addr;
  logic [LW-1:0]  first_len;
  logic [LW-1:0]  next_len;

  assign mi_addr  = burst_addr;
  assign mi_rw    = 1'b1;
  assign mi_valid = (state == ISSUE);
  assign busy     = (state != IDLE);

  always_comb begin
    frame_go   = cfg_run & frame_stb;
    line_go    = cfg_run & line_stb & ~frame_stb;
    fetch_req  = frame_go | (line_go & (rep_cnt == 4'd0));
    accept     = fetch_req & (state == IDLE);
    handshake  = (state == ISSUE) & mi_ready;
    rdone      = mi_rstb & mi_rlast;
    start_addr = frame_go ? cfg_base : line_addr;
    first_len  = (cfg_bn_cnt == '0) ? cfg_bl_len : cfg_bn_len;
    // Length of the burst following the current one once bursts_left drops.
    next_len   = (bursts_left == BURST_ONE) ? cfg_bl_len : cfg_bn_len;
    outstanding_next = outstanding;
    case ({handshake, rdone})
      2'b10:   outstanding_next = outstanding + OUT_ONE;
      2'b01:   outstanding_next = outstanding - OUT_ONE;
      default: outstanding_next = outstanding;
    endcase
  end

  // Trigger bookkeeping: repeat counter, bank ping-pong, next line address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt   <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      line_addr <= '0;
      underrun  <= 1'b0;
    end else begin
      underrun <= fetch_req & (state != IDLE);
      if (frame_go) begin
        rep_cnt <= '0;
        wr_bank <= 1'b0;
        rd_bank <= 1'b0;
        if (accept) line_addr <= cfg_base + cfg_stride;
      end else if (line_go) begin
        rep_cnt <= (rep_cnt == cfg_vrep) ? 4'd0 : rep_cnt + 4'd1;
        if (accept) begin
          rd_bank   <= wr_bank;
          wr_bank   <= ~wr_bank;
          line_addr <= line_addr + cfg_stride;
        end
      end
    end
  end

  // Burst issue state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      burst_addr  <= '0;
      mi_len      <= '0;
      bursts_left <= '0;
      outstanding <= '0;
      fetch_bank  <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      case (state)
        IDLE: begin
          if (accept) begin
            burst_addr  <= start_addr;
            bursts_left <= cfg_bn_cnt;
            mi_len      <= first_len;
            // A line fetch fills the bank that wr_bank flips to this cycle.
            fetch_bank  <= frame_go ? 1'b0 : ~wr_bank;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (mi_ready) begin
            burst_addr <= burst_addr + AW'(mi_len) + ADDR_ONE;
            if (bursts_left == '0) begin
              state <= DRAIN;
            end else begin
              bursts_left <= bursts_left - BURST_ONE;
              mi_len      <= next_len;
            end
          end
          if (!cfg_run) state <= DRAIN;
        end
        DRAIN: begin
          // Look one cycle ahead so busy drops right after the final rlast.
          if (outstanding_next == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line buffer write port; index wraps inside the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      buf_wren  <= 1'b0;
      buf_wdata <= '0;
      buf_waddr <= '0;
    end else begin
      buf_wren  <= mi_rstb;
      buf_wdata <= mi_rdata;
      buf_waddr <= {fetch_bank, idx};
      if (accept) idx <= '0;
      else if (mi_rstb) idx <= idx + IDX_ONE;
    end
  end

endmodule

// File: tb/tb_hdmi_line_dma.sv
// Scoreboard bench for hdmi_line_dma: directed fetch scenarios push the
// expected bursts and buffer writes into queues; a monitor pops and compares
// them whenever the DUT presents a burst handshake or a buffer write.
module tb_hdmi_line_dma;

  localparam int AW  = 23;
  localparam int LW  = 7;
  localparam int CW  = 7;
  localparam int BAW = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } burst_t;

  typedef struct packed {
    logic [BAW-1:0] waddr;
    logic [15:0]    data;
  } wr_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          last;
  } resp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_run = 1'b0;
  logic [AW-1:0]  cfg_base = '0;
  logic [AW-1:0]  cfg_stride = '0;
  logic [CW-1:0]  cfg_bn_cnt = '0;
  logic [LW-1:0]  cfg_bn_len = '0;
  logic [LW-1:0]  cfg_bl_len = '0;
  logic [3:0]     cfg_vrep = '0;
  logic           frame_stb = 1'b0;
  logic           line_stb = 1'b0;
  logic [AW-1:0]  mi_addr;
  logic [LW-1:0]  mi_len;
  logic           mi_rw;
  logic           mi_valid;
  logic           mi_ready = 1'b0;
  logic [15:0]    mi_rdata = '0;
  logic           mi_rstb = 1'b0;
  logic           mi_rlast = 1'b0;
  logic [BAW-1:0] buf_waddr;
  logic [15:0]    buf_wdata;
  logic           buf_wren;
  logic           rd_bank;
  logic           busy;
  logic           underrun;

  int checks = 0;
  int errors = 0;

  burst_t exp_b[$];
  wr_t    exp_w[$];
  resp_t  resp_q[$];

  hdmi_line_dma #(.AW(AW), .LW(LW), .CW(CW), .BAW(BAW)) dut (
    .clk(clk), .rst(rst), .cfg_run(cfg_run), .cfg_base(cfg_base),
    .cfg_stride(cfg_stride), .cfg_bn_cnt(cfg_bn_cnt), .cfg_bn_len(cfg_bn_len),
    .cfg_bl_len(cfg_bl_len), .cfg_vrep(cfg_vrep), .frame_stb(frame_stb),
    .line_stb(line_stb), .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
    .mi_valid(mi_valid), .mi_ready(mi_ready), .mi_rdata(mi_rdata),
    .mi_rstb(mi_rstb), .mi_rlast(mi_rlast), .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata), .buf_wren(buf_wren), .rd_bank(rd_bank),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
  endtask

  task automatic pulse_line();
    line_stb = 1'b1;
    tick();
    line_stb = 1'b0;
  endtask

  // Expected bursts and writes of one line fetch; nb_limit < nb_total models
  // a fetch cut short by cfg_run.
  task automatic push_fetch(input logic [AW-1:0] a0, input int unsigned nb_total,
                            input int unsigned nb_limit, input logic [LW-1:0] bn,
                            input logic [LW-1:0] bl, input logic bank);
    logic [AW-1:0] a;
    logic [LW-1:0] len;
    logic [8:0]    idx9;
    burst_t        b;
    wr_t           w;
    a = a0;
    idx9 = '0;
    for (int unsigned n = 0; n < nb_limit; n++) begin
      len = (n == nb_total - 1) ? bl : bn;
      b.addr = a;
      b.len  = len;
      exp_b.push_back(b);
      for (int unsigned k = 0; k <= 32'(len); k++) begin
        w.waddr = {bank, idx9};
        w.data  = mem_word(a + AW'(k));
        exp_w.push_back(w);
        idx9 = idx9 + 9'd1;
      end
      a = a + AW'(len) + AW'(1);
    end
  endtask

  // Waits for the final read word, then requires busy low one cycle later.
  task automatic wait_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (seen) begin
        chk({name, "_busy_drop"}, 32'(busy), 32'd0);
        #4;
        return;
      end
      seen = mi_rstb && mi_rlast && (resp_q.size() == 0) && (exp_b.size() == 0);
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Monitor: burst handshakes and buffer writes against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mi_valid && mi_ready) begin
        resp_t r;
        if (exp_b.size() == 0) begin
          chk("unexpected_burst", {2'b0, mi_addr, mi_len}, 32'd0);
        end else begin
          burst_t e;
          e = exp_b.pop_front();
          chk("burst", {2'b0, mi_addr, mi_len}, {2'b0, e.addr, e.len});
        end
        for (int unsigned k = 0; k <= 32'(mi_len); k++) begin
          r.addr = mi_addr + AW'(k);
          r.last = (k == 32'(mi_len));
          resp_q.push_back(r);
        end
      end
      if (buf_wren) begin
        if (exp_w.size() == 0) begin
          chk("unexpected_write", {6'b0, buf_waddr, buf_wdata}, 32'd0);
        end else begin
          wr_t e;
          e = exp_w.pop_front();
          chk("buf_write", {6'b0, buf_waddr, buf_wdata}, {6'b0, e.waddr, e.data});
        end
      end
    end
  end

  // Memory responder: one read word per cycle, in burst order.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        resp_q.delete();
        mi_rstb  = 1'b0;
        mi_rlast = 1'b0;
        mi_rdata = '0;
      end else if (resp_q.size() != 0) begin
        resp_t r;
        r = resp_q.pop_front();
        mi_rstb  = 1'b1;
        mi_rlast = r.last;
        mi_rdata = mem_word(r.addr);
      end else begin
        mi_rstb  = 1'b0;
        mi_rlast = 1'b0;
        mi_rdata = '0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk_reset(input string name);
    chk({name, "_mi_valid"}, 32'(mi_valid), 32'd0);
    chk({name, "_buf_wren"}, 32'(buf_wren), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_underrun"}, 32'(underrun), 32'd0);
    chk({name, "_rd_bank"}, 32'(rd_bank), 32'd0);
    chk({name, "_buf_waddr"}, 32'(buf_waddr), 32'd0);
    chk({name, "_buf_wdata"}, 32'(buf_wdata), 32'd0);
    chk({name, "_mi_addr"}, 32'(mi_addr), 32'd0);
    chk({name, "_mi_len"}, 32'(mi_len), 32'd0);
    chk({name, "_mi_rw"}, 32'(mi_rw), 32'd1);
  endtask

  initial begin
    logic [3:0] rd_exp8;
    logic [7:0] fetch8;
    rst = 1'b1;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;
    cfg_run    = 1'b1;
    cfg_base   = 23'h100;
    cfg_stride = 23'h140;
    cfg_bn_cnt = 7'd4;
    cfg_bn_len = 7'd63;
    cfg_bl_len = 7'd63;
    cfg_vrep   = 4'd1;
    mi_ready   = 1'b1;
    tick();

    // Basic fetch: 5 bursts of 64 words into bank 0.
    push_fetch(23'h100, 5, 5, 7'd63, 7'd63, 1'b0);
    pulse_frame();
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_mi_valid", 32'(mi_valid), 32'd1);
    chk("basic_rd_bank", 32'(rd_bank), 32'd0);
    wait_idle("basic");

    // Line repeat with shorter lines: 8 + 4 words.
    cfg_bn_cnt = 7'd1;
    cfg_bn_len = 7'd7;
    cfg_bl_len = 7'd3;
    push_fetch(23'h240, 2, 2, 7'd7, 7'd3, 1'b1);
    pulse_line();
    chk("rep1_rd_bank", 32'(rd_bank), 32'd0);
    chk("rep1_busy", 32'(busy), 32'd1);
    wait_idle("rep1");
    pulse_line();
    chk("rep2_rd_bank", 32'(rd_bank), 32'd0);
    chk("rep2_busy", 32'(busy), 32'd0);
    tick();
    push_fetch(23'h380, 2, 2, 7'd7, 7'd3, 1'b0);
    pulse_line();
    chk("rep3_rd_bank", 32'(rd_bank), 32'd1);
    chk("rep3_busy", 32'(busy), 32'd1);
    wait_idle("rep3");
    pulse_line();
    chk("rep4_rd_bank", 32'(rd_bank), 32'd1);
    chk("rep4_busy", 32'(busy), 32'd0);
    tick();

    // Deep repeat: fetch only on line strobes 1 and 5.
    cfg_vrep = 4'd3;
    push_fetch(23'h100, 2, 2, 7'd7, 7'd3, 1'b0);
    pulse_frame();
    chk("deep_frame_rd_bank", 32'(rd_bank), 32'd0);
    wait_idle("deep_frame");
    fetch8  = 8'b0001_0001;
    rd_exp8 = 4'd0;
    for (int unsigned n = 0; n < 8; n++) begin
      if (fetch8[n]) begin
        if (n == 0) push_fetch(23'h240, 2, 2, 7'd7, 7'd3, 1'b1);
        else        push_fetch(23'h380, 2, 2, 7'd7, 7'd3, 1'b0);
      end
      pulse_line();
      chk($sformatf("deep%0d_rd_bank", n + 1), 32'(rd_bank), (n >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("deep%0d_busy", n + 1), 32'(busy), 32'(fetch8[n]));
      if (fetch8[n]) wait_idle($sformatf("deep%0d", n + 1));
      else tick();
    end

    // Underrun: line strobe during DRAIN is dropped.
    cfg_vrep = 4'd0;
    push_fetch(23'h4C0, 2, 2, 7'd7, 7'd3, 1'b1);
    pulse_line();
    chk("ur_first_rd_bank", 32'(rd_bank), 32'd0);
    tick();
    tick();
    tick();
    chk("ur_draining_busy", 32'(busy), 32'd1);
    chk("ur_draining_valid", 32'(mi_valid), 32'd0);
    pulse_line();
    chk("ur_pulse", 32'(underrun), 32'd1);
    chk("ur_rd_bank_held", 32'(rd_bank), 32'd0);
    tick();
    chk("ur_pulse_end", 32'(underrun), 32'd0);
    wait_idle("ur_first");
    push_fetch(23'h600, 2, 2, 7'd7, 7'd3, 1'b0);
    pulse_line();
    chk("ur_next_rd_bank", 32'(rd_bank), 32'd1);
    chk("ur_next_underrun", 32'(underrun), 32'd0);
    wait_idle("ur_next");

    // Backpressure: mi_ready low for 5 cycles with the first burst pending.
    cfg_bn_cnt = 7'd2;
    cfg_bn_len = 7'd3;
    cfg_bl_len = 7'd1;
    mi_ready   = 1'b0;
    push_fetch(23'h740, 3, 3, 7'd3, 7'd1, 1'b1);
    pulse_line();
    chk("bp_rd_bank", 32'(rd_bank), 32'd0);
    for (int unsigned n = 0; n < 5; n++) begin
      chk("bp_valid", 32'(mi_valid), 32'd1);
      chk("bp_addr", 32'(mi_addr), 32'h740);
      chk("bp_len", 32'(mi_len), 32'd3);
      tick();
    end
    mi_ready = 1'b1;
    wait_idle("bp");

    // Stop: cfg_run cleared after 2 of 3 bursts.
    push_fetch(23'h880, 3, 2, 7'd3, 7'd1, 1'b0);
    pulse_line();
    chk("stop_rd_bank", 32'(rd_bank), 32'd1);
    tick();
    tick();
    mi_ready = 1'b0;
    cfg_run  = 1'b0;
    tick();
    chk("stop_no_valid", 32'(mi_valid), 32'd0);
    chk("stop_busy", 32'(busy), 32'd1);
    mi_ready = 1'b1;
    wait_idle("stop");
    cfg_run = 1'b1;
    tick();

    // Reset in the middle of ISSUE.
    mi_ready = 1'b0;
    pulse_line();
    chk("rst_issue_valid", 32'(mi_valid), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    mi_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(mi_valid), 32'd0);
    tick();

    chk("leftover_bursts", 32'(exp_b.size()), 32'd0);
    chk("leftover_writes", 32'(exp_w.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_line_dma.md
# hdmi_line_dma

Parametrised scanline fetch engine for the HDMI video path. It runs in the system clock domain and turns frame-start and line-start strobes into a sequence of burst reads on the memory interface. Returned words go into one bank of a two-bank line buffer, and the block tells the pixel-side reader which bank to display. Compared with the fixed line-doubling fetcher it adds:
- programmable vertical repeat (1–16×),
- an explicit line stride,
- parametrised widths,
- drain-safe stop,
- underrun detection.

## Interface
Parameters:
- AW, 23: memory word address width.
- LW, 7: burst length field width; lengths are encoded as N-1.
- CW, 7: burst count width.
- BAW, 10: line buffer write address width; MSB is the bank bit.

Ports:
- clk  in  1  system clock; the only clock of the block.
- rst  in  1  reset, synchronous, active-high.
- cfg_run  in  1  enable; 0 stops new fetches.
- cfg_base  in  AW  frame base word address.
- cfg_stride  in  AW  word distance between consecutive source lines.
- cfg_bn_cnt  in  CW  number of normal bursts per line.
- cfg_bn_len  in  LW  normal burst length minus 1.
- cfg_bl_len  in  LW  last burst length minus 1.
- cfg_vrep  in  4  each source line is shown cfg_vrep+1 times.
- frame_stb  in  1  frame start pulse, already synchronised to clk.
- line_stb  in  1  active line start pulse, already synchronised to clk.
- mi_addr  out  AW  burst start address.
- mi_len  out  LW  burst length minus 1.
- mi_rw  out  1  constant 1 (read).
- mi_valid  out  1  burst request.
- mi_ready  in  1  request accepted.
- mi_rdata  in  16  read data.
- mi_rstb  in  1  read data valid.
- mi_rlast  in  1  last word of a burst.
- buf_waddr  out  BAW  line buffer write address.
- buf_wdata  out  16  line buffer write data.
- buf_wren  out  1  line buffer write enable.
- rd_bank  out  1  bank the pixel side must read.
- busy  out  1  fetch in progress (state ≠ IDLE).
- underrun  out  1  one-cycle pulse when a fetch request is dropped.

## Operation
- **Trigger logic (registered):**
  - frame_stb takes priority over line_stb when both arrive in the same cycle.
  - On frame_stb:
    - rep_cnt:=0; wr_bank:=0; rd_bank:=0.
    - Fetch source line 0 from cfg_base. The next line address becomes cfg_base+cfg_stride.
  - On line_stb:
    - A fetch is requested only if rep_cnt==0.
    - rep_cnt := (rep_cnt==cfg_vrep) ? 0 : rep_cnt+1.
  - On an accepted line fetch: rd_bank:=wr_bank; wr_bank:=~wr_bank; line_addr += cfg_stride.
- **Triggers ignored:** all triggers are ignored while cfg_run=0; rep_cnt is held.
- **Underrun:** a fetch request arriving while busy=1 is dropped.
  - underrun pulses for one cycle.
  - wr_bank, rd_bank and line_addr are unchanged; rep_cnt still advances.
  - The frame_stb reset actions still apply; only its fetch is dropped.
- **State machine IDLE → ISSUE → DRAIN → IDLE:**
  - IDLE: on an accepted fetch, load burst_addr:=line start, bursts_left:=cfg_bn_cnt, word index:=0, then go to ISSUE.
  - ISSUE: mi_valid=1.
    - mi_len = (bursts_left==0) ? cfg_bl_len : cfg_bn_len.
    - On mi_valid&mi_ready: burst_addr += mi_len+1 (zero-extended to AW) and outstanding++.
    - Handshake on the last burst (bursts_left==0) → DRAIN; otherwise bursts_left--.
    - cfg_run falling → DRAIN without issuing further bursts.
  - DRAIN: wait until outstanding==0, then → IDLE.
- **Outstanding counter:** CW+1 bits; +1 per accepted burst, −1 per mi_rlast&mi_rstb, both in the same cycle leave it unchanged.
- **Address arithmetic:** all address arithmetic is modulo 2^AW. The buffer word index is BAW-1 bits and wraps modulo 2^(BAW-1); writes beyond the bank size wrap within the bank and never touch the other bank.
- **Buffer write (registered):** buf_wren<=mi_rstb; buf_wdata<=mi_rdata; buf_waddr<={wr_bank_of_fetch, idx}; idx++ per mi_rstb.
- **Configuration sampling:** cfg_* are sampled when a fetch starts or a burst is issued; changing them mid-line is allowed but gives undefined line content.

## Timing
- Reset values: mi_valid=0, buf_wren=0, busy=0, underrun=0, rd_bank=0, buf_waddr=0, buf_wdata=0, mi_addr=0, mi_len=0. Reset mid-burst abandons outstanding reads; the memory controller is reset by the same rst.
- Strobe at cycle t → busy and mi_valid high at t+1.
- mi_addr and mi_len hold stable while mi_valid=1 and mi_ready=0.
- Back-to-back bursts: the next request is presented in the cycle after a handshake, i.e. one request per cycle when mi_ready is held high.
- mi_rstb at t → buf_wren at t+1.
- rd_bank updates at t+1 after the accepting line_stb.
- busy drops the cycle after the final mi_rlast.

## Test plan
- **Basic fetch:** base=0x100, stride=0x140, bn_cnt=4, bn_len=63, bl_len=63, vrep=1, frame_stb, mi_ready=1 → bursts at 0x100, 0x140, 0x180, 0x1C0, 0x200, all len 63; 320 writes to bank 0 at idx 0..319; busy clears after the 5th rlast.
- **Line repeat:** vrep=1, frame_stb then 4 line_stb → fetches on line_stb #1 (addr 0x240, bank 1) and #3 (addr 0x380, bank 0); rd_bank = 0, 0, 1, 1.
- **Deep repeat:** vrep=3 → fetches on every 4th line_stb only.
- **Underrun:** line_stb while a fetch is draining → underrun pulse, no new mi_valid, banks unchanged; the following line_stb fetches normally.
- **Backpressure:** mi_ready low for 5 cycles during ISSUE → mi_addr/mi_len stable; no burst lost or duplicated.
- **Stop and reset:** cfg_run cleared after 2 bursts → no 3rd burst, DRAIN completes after 2 rlast; rst mid-ISSUE → all outputs at reset values the next cycle.
